// File: rtl/depthbuffer_ctrl.sv
// depthbuffer_ctrl: per-frame clear sweep, then fragment forwarding with depth compare, then pipeline drain
`timescale 1ns/1ps
module depthbuffer_ctrl #(
    parameter int          FB_WIDTH     = 160,
    parameter int          FB_HEIGHT    = 120,
    parameter int          PIPE_LATENCY = 3,
    parameter logic [31:0] CLEAR_DEPTH  = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] clear_color,
    input  logic        frag_valid,
    output logic        frag_ready,
    input  logic [11:0] frag_color,
    input  logic [31:0] frag_depth,
    input  logic [15:0] frag_x,
    input  logic [15:0] frag_y,
    input  logic        frag_last,
    output logic        db_valid,
    output logic        db_compare_depth,
    output logic [11:0] db_color,
    output logic [31:0] db_depth,
    output logic [15:0] db_x,
    output logic [15:0] db_y,
    output logic        busy,
    output logic        clearing,
    output logic        frame_done
);
    localparam int XW = FB_WIDTH > 1 ? $clog2(FB_WIDTH) : 1;
    localparam int YW = FB_HEIGHT > 1 ? $clog2(FB_HEIGHT) : 1;
    localparam int DW = $clog2(PIPE_LATENCY + 2);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
    state_t        state_q;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [11:0]   color_q;
    logic [DW-1:0] drain_q;
    logic          accept, in_range, x_wrap, last_px;
    assign accept   = frag_valid & frag_ready;
    assign in_range = (frag_x < 16'(FB_WIDTH)) && (frag_y < 16'(FB_HEIGHT));
    assign x_wrap   = cx_q == XW'(FB_WIDTH - 1);
    assign last_px  = x_wrap && (cy_q == YW'(FB_HEIGHT - 1));
    // raster-order successor of the current clear pixel, x fastest
    always_comb begin
        cx_d = x_wrap ? '0 : cx_q + 1'b1;
        cy_d = last_px ? '0 : (x_wrap ? cy_q + 1'b1 : cy_q);
    end
    // frame sequencer; every output is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cx_q             <= '0;
            cy_q             <= '0;
            color_q          <= '0;
            drain_q          <= '0;
            frag_ready       <= 1'b0;
            busy             <= 1'b0;
            clearing         <= 1'b0;
            frame_done       <= 1'b0;
            db_valid         <= 1'b0;
            db_compare_depth <= 1'b0;
            db_color         <= '0;
            db_depth         <= '0;
            db_x             <= '0;
            db_y             <= '0;
        end else begin
            db_valid         <= 1'b0;
            db_compare_depth <= 1'b0;
            db_color         <= '0;
            db_depth         <= '0;
            db_x             <= '0;
            db_y             <= '0;
            frame_done       <= 1'b0;
            case (state_q)
                IDLE: if (frame_start) begin
                    state_q  <= CLEAR;
                    color_q  <= clear_color;
                    cx_q     <= '0;
                    cy_q     <= '0;
                    busy     <= 1'b1;
                    clearing <= 1'b1;
                end
                CLEAR: begin
                    db_valid <= 1'b1;
                    db_depth <= CLEAR_DEPTH;
                    db_color <= color_q;
                    db_x     <= 16'(cx_q);
                    db_y     <= 16'(cy_q);
                    cx_q     <= cx_d;
                    cy_q     <= cy_d;
                    if (last_px) begin
                        state_q    <= RUN;
                        clearing   <= 1'b0;
                        frag_ready <= 1'b1;
                    end
                end
                RUN: if (accept) begin
                    if (in_range) begin
                        db_valid         <= 1'b1;
                        db_compare_depth <= 1'b1;
                        db_color         <= frag_color;
                        db_depth         <= frag_depth;
                        db_x             <= frag_x;
                        db_y             <= frag_y;
                    end
                    if (frag_last) begin
                        state_q    <= DRAIN;
                        frag_ready <= 1'b0;
                        drain_q    <= '0;
                        frame_done <= PIPE_LATENCY == 0;
                    end
                end
                DRAIN: if (frame_done) begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    drain_q <= '0;
                end else begin
                    drain_q    <= drain_q + DW'(1);
                    frame_done <= (drain_q + DW'(1)) == DW'(PIPE_LATENCY);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_depthbuffer_ctrl.sv
// tb_depthbuffer_ctrl: randomized frames against a queue-based reference of the depth-stage traffic
`timescale 1ns/1ps
module tb_depthbuffer_ctrl;
    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 3;
    typedef struct packed {
        logic        cmp;
        logic [11:0] color;
        logic [31:0] depth;
        logic [15:0] x;
        logic [15:0] y;
    } db_t;
    logic clk = 0, rst = 1, frame_start = 0, frag_valid = 0, frag_last = 0;
    logic [11:0] clear_color = 0, frag_color = 0;
    logic [31:0] frag_depth = 0;
    logic [15:0] frag_x = 0, frag_y = 0;
    logic frag_ready, db_valid, db_compare_depth, busy, clearing, frame_done;
    logic [11:0] db_color;
    logic [31:0] db_depth;
    logic [15:0] db_x, db_y;
    int checks = 0, errors = 0;
    db_t exp_q[$];

    depthbuffer_ctrl #(.FB_WIDTH(W), .FB_HEIGHT(H), .PIPE_LATENCY(L), .CLEAR_DEPTH(32'h7FFF_FFFF)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .clear_color(clear_color),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_color(frag_color),
        .frag_depth(frag_depth), .frag_x(frag_x), .frag_y(frag_y), .frag_last(frag_last),
        .db_valid(db_valid), .db_compare_depth(db_compare_depth), .db_color(db_color),
        .db_depth(db_depth), .db_x(db_x), .db_y(db_y), .busy(busy), .clearing(clearing),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // monitor: every depth-stage transaction must match the oldest expectation
    always @(negedge clk) begin
        if (db_valid) begin
            db_t act, e;
            act = {db_compare_depth, db_color, db_depth, db_x, db_y};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL db_unexpected got %h want none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL db_txn got %h want %h", act, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_frame(input bit directed, input bit abort);
        logic [11:0] c;
        logic [15:0] dx[3], dy[3];
        int n, bad, nf, sent, k;
        dx = '{16'd2, 16'd4, 16'd0};
        dy = '{16'd1, 16'd0, 16'd3};
        c = directed ? 12'hABC : 12'($urandom);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!abort || y * W + x < 4)
                    exp_q.push_back({1'b0, c, 32'h7FFF_FFFF, 16'(x), 16'(y)});
        frame_start = 1;
        clear_color = c;
        @(negedge clk);
        frame_start = 0;
        clear_color = 12'($urandom);
        if (abort) begin
            repeat (4) @(negedge clk);
            rst = 1;
            @(negedge clk);
            rst = 0;
            chk("abort_valid", 64'(db_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_queue", 64'(exp_q.size()), 64'd0);
            return;
        end
        n = 0;
        bad = 0;
        while (!frag_ready && n < 100) begin
            if (!clearing) bad++;
            n++;
            frame_start = (n == 4);
            @(negedge clk);
        end
        frame_start = 0;
        chk("clear_len", 64'(n), 64'(W * H));
        chk("clear_flag", 64'(bad), 64'd0);
        chk("run_flags", 64'({busy, clearing}), 64'b10);
        nf = directed ? 5 : $urandom_range(3, 9);
        sent = 0;
        bad = 0;
        while (sent < nf) begin
            if (!frag_ready) bad++;
            frag_valid = directed || $urandom_range(0, 3) != 0;
            frag_x = directed && sent < 3 ? dx[sent] :
                     ($urandom_range(0, 9) == 0 ? 16'hFFFF : 16'($urandom_range(0, W + 1)));
            frag_y = directed && sent < 3 ? dy[sent] : 16'($urandom_range(0, H + 1));
            frag_depth = directed && sent == 0 ? 32'h0001_0000 : $urandom;
            frag_color = directed && sent == 0 ? 12'h0F0 : 12'($urandom);
            frag_last = sent == nf - 1;
            frame_start = !directed && $urandom_range(0, 5) == 0;
            if (frag_valid) begin
                if (frag_x < W && frag_y < H)
                    exp_q.push_back({1'b1, frag_color, frag_depth, frag_x, frag_y});
                sent++;
            end
            @(negedge clk);
        end
        frag_valid = 0;
        frag_last = 0;
        frame_start = 0;
        chk("run_ready", 64'(bad), 64'd0);
        chk("ready_drop", 64'(frag_ready), 64'd0);
        k = 1;
        while (!frame_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drain_len", 64'(k), 64'(L + 1));
        chk("done_busy", 64'(busy), 64'd1);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        chk("done_pulse", 64'(frame_done), 64'd0);
        chk("idle_flags", 64'({busy, clearing, frag_ready}), 64'd0);
        @(negedge clk);
        chk("start_ignored", 64'({busy, clearing}), 64'd0);
        chk("frame_queue", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_db", 64'({db_valid, db_compare_depth, db_color, db_depth, db_x}), 64'd0);
        chk("reset_ctl", 64'({db_y, frag_ready, busy, clearing, frame_done}), 64'd0);
        rst = 0;
        @(negedge clk);
        do_frame(1, 0);
        do_frame(0, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_frame(0, 0);
        repeat (5) @(negedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/depthbuffer_ctrl.md
Name: depthbuffer_ctrl

Overview:
Frame sequencer placed in front of the depth-test stage. On each frame start it sweeps every pixel with a clear write (depth = CLEAR_DEPTH, compare disabled, color = clear_color). It then forwards rasterizer fragments with depth compare enabled, stalling the rasterizer during the clear. After the last fragment it waits out the depth-stage pipeline latency and pulses frame_done.

Parameters:
FB_WIDTH, 160, framebuffer width in pixels
FB_HEIGHT, 120, framebuffer height in pixels
PIPE_LATENCY, 3, cycles from db_valid to the depth stage's out_valid
CLEAR_DEPTH, 32'h7FFF_FFFF, Q16.16 depth written during clear (farthest)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_start  in  1  single-cycle pulse; begins clear+render of a frame
clear_color  in  12  color12_t written to every pixel during clear; sampled on accepted frame_start
frag_valid  in  1  rasterizer fragment valid
frag_ready  out  1  controller accepts fragment this cycle
frag_color  in  12  color12_t fragment color
frag_depth  in  32  q16_16_t fragment depth
frag_x  in  16  fragment x
frag_y  in  16  fragment y
frag_last  in  1  marks last fragment of frame (qualified by frag_valid&frag_ready)
db_valid  out  1  to depth stage in_valid
db_compare_depth  out  1  to depth stage in_compare_depth
db_color  out  12  to depth stage in_color
db_depth  out  32  to depth stage in_depth
db_x  out  16  to depth stage in_x
db_y  out  16  to depth stage in_y
busy  out  1  high in any state except IDLE
clearing  out  1  high in CLEAR
frame_done  out  1  single-cycle pulse at end of DRAIN

Behaviour:
- Reset: state IDLE. All outputs 0: db_*, frag_ready, busy, clearing, frame_done. Clear counters and drain counter zeroed. Reset mid-clear or mid-frame aborts immediately; no further db_valid.
- All db_* outputs are registered: 1-cycle latency from state/handshake to db_valid.
- IDLE: frag_ready=0. frame_start=1 -> CLEAR; latch clear_color; cx=cy=0.
- CLEAR: one pixel per cycle, raster order, x fastest.
  - Each cycle: db_valid=1, db_compare_depth=0, db_depth=CLEAR_DEPTH, db_color=latched clear color, db_x=cx, db_y=cy.
  - cx wraps at FB_WIDTH-1 to 0 and increments cy.
  - After pixel (FB_WIDTH-1, FB_HEIGHT-1) -> RUN.
  - Exactly FB_WIDTH*FB_HEIGHT consecutive db_valid cycles; frag_ready=0 throughout.
- RUN: frag_ready=1 (the depth stage has no backpressure).
  - On accept: db_valid=1, db_compare_depth=1, frag fields copied to db_*.
  - Fragments with frag_x>=FB_WIDTH or frag_y>=FB_HEIGHT are accepted but dropped (db_valid=0).
  - Accept with frag_last=1 (dropped or not) -> DRAIN with drain count=0; frag_ready=0 from the next cycle.
  - No fragment -> db_valid=0, db_* data fields 0.
- DRAIN: db_valid=0. Counter runs to PIPE_LATENCY; then frame_done=1 for one cycle and -> IDLE.
- frame_start outside IDLE is ignored (no restart, no queueing).
- frame_start and the frame_done cycle coinciding: frame_start is ignored (state is DRAIN); a new frame needs a pulse while IDLE.
- busy = (state != IDLE); clearing = (state == CLEAR). Both are registered alongside the state.
- Width rules:
  - cx width $clog2(FB_WIDTH); cy width $clog2(FB_HEIGHT). Zero-extend to 16 on db_x/db_y.
  - Range check uses the full 16-bit unsigned compare.

Test Plan:
- FB_WIDTH=4, FB_HEIGHT=3; pulse frame_start with clear_color=12'hABC -> 12 consecutive db_valid cycles, (x,y)=(0,0),(1,0)..(3,2), compare=0, depth=32'h7FFF_FFFF, color=ABC; frag_ready=0 throughout, clearing=1, then frag_ready=1.
- RUN: fragment (x=2,y=1,depth=32'h0001_0000,color=12'h0F0) -> next cycle db_valid=1, compare=1, identical fields.
- RUN: fragments (x=4,y=0) and (x=0,y=3) -> accepted (frag_ready=1) but db_valid stays 0.
- Last fragment with frag_last=1 at cycle T -> frag_ready=0 from T+1; frame_done pulses once after PIPE_LATENCY drain cycles; busy falls with return to IDLE.
- frame_start pulsed mid-CLEAR and mid-RUN -> no counter restart; total clear count still 12.
- rst asserted at the 5th clear cycle -> next cycle db_valid=0, busy=0; a following frame_start restarts the clear at (0,0).
